// File: rtl/ula_result_fifo.sv
// Four-entry FIFO buffering ULA results {carry, zero, result} for a downstream consumer.
// Optional write-drop counter is enabled by defining ULA_FIFO_DROP_CNT_EN.
module ula_result_fifo (
    input  logic       clk,
    input  logic       R,
    input  logic [6:0] O_in,
    input  logic       carry_in,
    input  logic       zero_in,
    input  logic       we,
    input  logic       rd_ready,
    output logic       rd_valid,
    output logic [6:0] rd_data,
    output logic       rd_carry,
    output logic       rd_zero,
    output logic [2:0] count,
    output logic       full
`ifdef ULA_FIFO_DROP_CNT_EN
    ,
    output logic [3:0] drop_cnt
`endif
);

    logic [8:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic       pop;
    logic       push;

    assign rd_valid = (count != 3'd0);
    assign full     = (count == 3'd4);
    assign pop      = rd_valid & rd_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts the write.
    assign push     = we & (~full | pop);

    assign {rd_carry, rd_zero, rd_data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!R) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage is never cleared; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (R && push) mem[wr_ptr] <= {carry_in, zero_in, O_in};
    end

`ifdef ULA_FIFO_DROP_CNT_EN
    logic drop;

    assign drop = we & full & ~pop;

    always_ff @(posedge clk) begin
        if (!R)
            drop_cnt <= 4'd0;
        else if (drop && drop_cnt != 4'hF)
            drop_cnt <= drop_cnt + 4'd1;
    end
`endif

endmodule

// File: tb/tb_ula_result_fifo.sv
// Directed self-checking bench for ula_result_fifo; checks the drop counter when
// ULA_FIFO_DROP_CNT_EN is defined.
module tb_ula_result_fifo;

    logic       clk = 1'b0;
    logic       R = 1'b0;
    logic [6:0] O_in = 7'h00;
    logic       carry_in = 1'b0;
    logic       zero_in = 1'b0;
    logic       we = 1'b0;
    logic       rd_ready = 1'b0;
    logic       rd_valid;
    logic [6:0] rd_data;
    logic       rd_carry;
    logic       rd_zero;
    logic [2:0] count;
    logic       full;
`ifdef ULA_FIFO_DROP_CNT_EN
    logic [3:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    ula_result_fifo dut (
        .clk      (clk),
        .R        (R),
        .O_in     (O_in),
        .carry_in (carry_in),
        .zero_in  (zero_in),
        .we       (we),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_carry (rd_carry),
        .rd_zero  (rd_zero),
        .count    (count),
        .full     (full)
`ifdef ULA_FIFO_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic w, input logic [6:0] d, input logic c, input logic z,
                         input logic rdy);
        we       = w;
        O_in     = d;
        carry_in = c;
        zero_in  = z;
        rd_ready = rdy;
        tick();
        we       = 1'b0;
        rd_ready = 1'b0;
    endtask

    initial begin
        logic [6:0] exp_d;

        // reset with a write pending: the write must be lost
        R = 1'b0;
        cycle(1'b1, 7'h55, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
`ifdef ULA_FIFO_DROP_CNT_EN
        chk("rst_drop", 32'(drop_cnt), 32'd0);
`endif
        R = 1'b1;

        // single push, zero-latency head
        cycle(1'b1, 7'h05, 1'b0, 1'b0, 1'b0);
        chk("push1_valid", 32'(rd_valid), 32'd1);
        chk("push1_data", 32'(rd_data), 32'h05);
        chk("push1_count", 32'(count), 32'd1);
        cycle(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
        chk("pop1_valid", 32'(rd_valid), 32'd0);

        // push into empty with rd_ready high: stored, not popped
        cycle(1'b1, 7'h11, 1'b1, 1'b0, 1'b1);
        chk("empty_pushrdy_count", 32'(count), 32'd1);
        chk("empty_pushrdy_data", 32'(rd_data), 32'h11);
        chk("empty_pushrdy_carry", 32'(rd_carry), 32'd1);
        cycle(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);

        // rd_ready while empty is harmless
        cycle(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
        chk("empty_rdy_count", 32'(count), 32'd0);

        // fill to full, then a dropped write
        for (int i = 1; i <= 4; i++) cycle(1'b1, 7'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
        cycle(1'b1, 7'h7F, 1'b1, 1'b1, 1'b0);
        chk("drop_count", 32'(count), 32'd4);
        chk("drop_head", 32'(rd_data), 32'h01);
`ifdef ULA_FIFO_DROP_CNT_EN
        chk("drop_cnt1", 32'(drop_cnt), 32'd1);
`endif
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_data%0d", i), 32'(rd_data), 32'(i));
            chk($sformatf("drain_valid%0d", i), 32'(rd_valid), 32'd1);
            cycle(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
        end
        chk("drain_empty", 32'(rd_valid), 32'd0);

        // full with simultaneous push+pop: accepted, no drop
        for (int i = 1; i <= 4; i++) cycle(1'b1, 7'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 7'h00, 1'b0, 1'b1, 1'b1);
        chk("fullpp_count", 32'(count), 32'd4);
        chk("fullpp_head", 32'(rd_data), 32'h02);
`ifdef ULA_FIFO_DROP_CNT_EN
        chk("fullpp_drop", 32'(drop_cnt), 32'd1);
`endif
        for (int i = 2; i <= 4; i++) begin
            chk($sformatf("fullpp_data%0d", i), 32'(rd_data), 32'(i));
            cycle(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
        end
        chk("fullpp_last_data", 32'(rd_data), 32'h00);
        chk("fullpp_last_zero", 32'(rd_zero), 32'd1);
        chk("fullpp_last_valid", 32'(rd_valid), 32'd1);
        cycle(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
        chk("fullpp_empty", 32'(rd_valid), 32'd0);

        // steady push+pop at count=2, pointers wrap several times
        cycle(1'b1, 7'h40, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 7'h41, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp_d = 7'h40 + 7'(i);
            chk($sformatf("stream_data%0d", i), 32'(rd_data), 32'(exp_d));
            chk($sformatf("stream_carry%0d", i), 32'(rd_carry), 32'(i % 2));
            cycle(1'b1, 7'h42 + 7'(i), 1'(i % 2), 1'(i / 2 % 2), 1'b1);
            chk($sformatf("stream_count%0d", i), 32'(count), 32'd2);
        end
        chk("stream_tail0", 32'(rd_data), 32'h4A);
        cycle(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
        chk("stream_tail1", 32'(rd_data), 32'h4B);
        chk("stream_tail1_carry", 32'(rd_carry), 32'd1);
        chk("stream_tail1_zero", 32'(rd_zero), 32'd0);
        cycle(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
        chk("stream_empty", 32'(rd_valid), 32'd0);

        // reset with count=3 and a concurrent write
        for (int i = 0; i < 3; i++) cycle(1'b1, 7'h20 + 7'(i), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd3);
        R = 1'b0;
        cycle(1'b1, 7'h2F, 1'b0, 1'b0, 1'b1);
        R = 1'b1;
        chk("rst3_count", 32'(count), 32'd0);
        chk("rst3_valid", 32'(rd_valid), 32'd0);
`ifdef ULA_FIFO_DROP_CNT_EN
        chk("rst3_drop", 32'(drop_cnt), 32'd0);
`endif

        // first edge after reset accepts a push
        cycle(1'b1, 7'h33, 1'b0, 1'b1, 1'b0);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_data", 32'(rd_data), 32'h33);
        chk("post_rst_zero", 32'(rd_zero), 32'd1);

        // 20 writes into a full FIFO
        for (int i = 0; i < 3; i++) cycle(1'b1, 7'h34 + 7'(i), 1'b0, 1'b0, 1'b0);
        chk("sat_full", 32'(full), 32'd1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 7'h60 + 7'(i), 1'b1, 1'b1, 1'b0);
`ifdef ULA_FIFO_DROP_CNT_EN
            if (i == 13) chk("sat_drop14", 32'(drop_cnt), 32'd14);
`endif
        end
`ifdef ULA_FIFO_DROP_CNT_EN
        chk("sat_drop15", 32'(drop_cnt), 32'd15);
`endif
        chk("sat_count", 32'(count), 32'd4);
        chk("sat_head", 32'(rd_data), 32'h33);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sat_drain%0d", i), 32'(rd_data), 32'(7'h33 + 7'(i)));
            cycle(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
        end
        chk("sat_empty", 32'(rd_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
